apb_req_arbiter: RTL
====================

Name: apb_req_arbiter

Overview:
- Multi-requester APB master front-end that shares a single APB completer between NREQ internal requesters.
- Each requester uses a valid/ready command port and gets a one-cycle response pulse.
- The block arbitrates round-robin, sequences APB SETUP/ACCESS phases, honours PREADY wait states, and returns PRDATA/PSLVERR to the granted requester.
- Sits between bus-master logic (DMA, CPU shim, test sequencers) and the APB register/memory completer.

Parameters:
- NREQ, 2: number of requesters (2..8).
- DW, 32: APB data width.
- AW, 12: APB address width.
- TIMEOUT, 16: max PREADY-low cycles in ACCESS. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  asynchronous active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_write  in  NREQ  per-requester direction; 1 = write.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot command accept.
- rsp_valid  out  NREQ  one-hot one-cycle response pulse.
- rsp_rdata  out  DW  read data; meaningful only with rsp_valid on a read.
- rsp_err  out  1  error flag qualified by rsp_valid.
- PADDR  out  AW  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset: PRESET high clears all registered outputs to 0 immediately (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err), state=IDLE, rr_ptr=0. Any in-flight transfer is abandoned with no response.
- FSM states:
  - IDLE: if any req_valid, grant the first set bit searching from rr_ptr upward with wrap. req_ready[g] is asserted combinationally in this cycle only. Latch addr/write/wdata and grant index g. Next state SETUP. If no req_valid, remain in IDLE.
  - SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latch. Next state ACCESS.
  - ACCESS: PSEL=1, PENABLE=1. Remain while PREADY=0, holding all APB outputs stable. When PREADY=1:
    - sample PRDATA into rsp_rdata (reads) and PSLVERR into rsp_err;
    - rr_ptr = (g+1) mod NREQ;
    - next state RESP.
  - RESP: rsp_valid[g]=1 for exactly one cycle; PSEL=0, PENABLE=0. Arbitration in this cycle is identical to IDLE (next grant may be accepted here), so the APB bus idles exactly one cycle between transfers.
- req_ready is 0 in SETUP and ACCESS.
- Latency with zero wait states:
  - accept at cycle 0;
  - SETUP at cycle 1;
  - ACCESS at cycle 2;
  - rsp_valid at cycle 3.
  - Each PREADY-low cycle adds one.
- Writes: rsp_rdata is driven 0. Reads: PWDATA is driven 0.
- Requester rules: req_valid, req_addr, req_write and req_wdata must be held stable until req_ready. A requester may re-request in the same cycle its rsp_valid pulses.
- Addresses pass through unmodified; no alignment checks.
- PSLVERR is forwarded to rsp_err and is not treated as a fatal error.
- Simultaneous requests: round-robin only. A requester that was just serviced has lowest priority at the next grant.
- PREADY and PSLVERR are ignored outside ACCESS.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - an 8-bit wait counter clears on SETUP and increments each ACCESS cycle with PREADY=0;
  - when the counter reaches TIMEOUT with PREADY still 0, the block goes to RESP;
  - PSEL and PENABLE drop on the next edge;
  - response is rsp_err=1 and rsp_rdata=0;
  - rr_ptr advances as normal.
- Undefined: no counter is built, ACCESS waits on PREADY indefinitely, and the TIMEOUT parameter is ignored.

Test Plan:
- Single write, req 0, addr 0x010, data 0xDEADBEEF, PREADY=1:
  - PSEL rises at cycle 1; PENABLE at cycle 2 with PADDR=0x010, PWRITE=1, PWDATA=0xDEADBEEF;
  - rsp_valid=2'b01 at cycle 3, rsp_err=0.
- Read with 2 wait states, req 1, addr 0x004, PREADY low 2 cycles, then PRDATA=0x12345678:
  - ACCESS lasts 3 cycles with outputs stable;
  - rsp_valid=2'b10 at cycle 5, rsp_rdata=0x12345678.
- Both requesters valid continuously from reset, 4 transfers:
  - grant order 0,1,0,1;
  - one idle PSEL=0 cycle between transfers;
  - each requester's req_ready asserts exactly once per grant.
- PSLVERR=1 on a read from req 0:
  - rsp_err=1 with rsp_valid=2'b01;
  - the next transfer proceeds normally with rsp_err=0.
- PRESET pulsed high during ACCESS with PREADY=0:
  - PSEL/PENABLE drop to 0 asynchronously and no rsp_valid appears;
  - after release, the first request from req 1 is granted (rr_ptr=0, req 0 idle).
- With APB_TIMEOUT_EN, TIMEOUT=16, PREADY held 0:
  - the ACCESS phase ends after 16 wait cycles;
  - rsp_err=1, rsp_rdata=0;
  - the FSM returns to IDLE.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Shares one APB completer between NREQ internal requesters. Each requester
//   presents a valid/ready command. The block picks one round-robin, runs the
//   APB SETUP/ACCESS phases, waits out PREADY-low cycles, and returns a
//   one-cycle response pulse carrying PRDATA/PSLVERR to the granted requester.
//
//   Optional build macro APB_TIMEOUT_EN: when defined, an ACCESS phase that
//   sees TIMEOUT consecutive PREADY-low cycles is abandoned and answered with
//   rsp_err=1, rsp_rdata=0.
//
// Ports
//   PCLK, PRESET           clock, asynchronous active-high reset
//   req_valid/req_write    per-requester command valid / direction (1=write)
//   req_addr/req_wdata     packed per-requester address / write data
//   req_ready              one-hot command accept (combinational)
//   rsp_valid              one-hot one-cycle response pulse
//   rsp_rdata/rsp_err      response read data / error, qualified by rsp_valid
//   PADDR..PSLVERR         APB master interface
module apb_req_arbiter #(
   parameter int NREQ    = 2,
   parameter int DW      = 32,
   parameter int AW      = 12,
   parameter int TIMEOUT = 16
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    req_ready,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic [AW-1:0]      PADDR,
   output logic               PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [DW-1:0]      PWDATA,
   input  logic [DW-1:0]      PRDATA,
   input  logic               PREADY,
   input  logic               PSLVERR
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   cur_idx;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic            arb_en;
   logic            accept;
   logic            done;
   logic            timed_out;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            sel_write;

   // Arbitration is open in IDLE and in the RESP cycle, so back-to-back
   // transfers leave exactly one PSEL-low cycle on the bus.
   assign arb_en = (state == IDLE) || (state == RESP);
   assign accept = arb_en && gnt_any;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      logic [IW:0] pos;
      gnt_any = 1'b0;
      gnt_idx = '0;
      pos     = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, rr_ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
         if (!gnt_any && req_valid[pos[IW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = pos[IW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   // Command fields of the winning requester.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IW'(i)) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            sel_write = req_write[i];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // Fires on the TIMEOUT-th consecutive PREADY-low ACCESS cycle.
   assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)                       wait_cnt <= '0;
      else if (state == SETUP)          wait_cnt <= '0;
      else if (state == ACCESS && !PREADY) wait_cnt <= wait_cnt + 8'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign timed_out      = 1'b0;
`endif

   assign done = (state == ACCESS) && (PREADY || timed_out);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_any) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done) state_nxt = RESP;
         RESP:    state_nxt = gnt_any ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_idx   <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state   <= state_nxt;
         // APB strobes are registered from the next state so they are glitch-free.
         PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
         PENABLE <= (state_nxt == ACCESS);

         // The APB address/data registers double as the command latch; they
         // only change on accept, so they stay stable through wait states.
         if (accept) begin
            cur_idx <= gnt_idx;
            PADDR   <= sel_addr;
            PWRITE  <= sel_write;
            PWDATA  <= sel_write ? sel_wdata : '0;
         end

         rsp_valid <= '0;
         if (done) begin
            rsp_valid[cur_idx] <= 1'b1;
            rsp_rdata <= (PWRITE || timed_out) ? '0 : PRDATA;
            rsp_err   <= PSLVERR || timed_out;
            rr_ptr    <= (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;
         end
      end
   end

endmodule
